// File: rtl/aes128_round_ctrl_if.sv
`default_nettype none
// ============================================================================
// aes128_round_ctrl_if : host-side handshake bundle of the AES-128 sequencer
// Revision 1.0
// ============================================================================
interface aes128_round_ctrl_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, plaintext, key, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, plaintext, key, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface
`default_nettype wire

// File: rtl/aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// aes128_round_ctrl : iterative AES-128 encryption sequencer, one round/clock
// Revision 1.0
// ============================================================================
module aes128_round_ctrl (
  input  wire                clk,
  input  wire                rst_n,
  aes128_round_ctrl_if.slave host,
  output logic [127:0]       kexp_key_o,
  output logic [7:0]         kexp_rcon_o,
  input  wire  [127:0]       kexp_key_i,
  output logic [127:0]       rnd_state_o,
  output logic [127:0]       rnd_key_o,
  output logic               rnd_last_o,
  input  wire  [127:0]       rnd_state_i
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  fsm_t         fsm;
  fsm_t         fsm_nxt;
  logic [127:0] blk_state;
  logic [127:0] rkey;
  logic [3:0]   round;
  logic [7:0]   rcon;
  logic [7:0]   rcon_nxt;
  logic         accept;

  assign accept   = (fsm == IDLE) && host.in_valid;
  assign rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (host.in_valid)        fsm_nxt = ROUND;
      ROUND:   if (round == LAST_ROUND)  fsm_nxt = DONE;
      DONE:    if (host.out_ready)       fsm_nxt = IDLE;
      default:                           fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm <= IDLE;
    end else begin
      fsm <= fsm_nxt;
    end
  end

  // Initial AddRoundKey is folded into acceptance so ROUND only applies rounds 1..10.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_state <= '0;
      rkey      <= '0;
      round     <= '0;
      rcon      <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (accept) begin
            blk_state <= host.plaintext ^ host.key;
            rkey      <= host.key;
            round     <= 4'd1;
            rcon      <= 8'h01;
          end
        end
        ROUND: begin
          blk_state <= rnd_state_i;
          rkey      <= kexp_key_i;
          rcon      <= rcon_nxt;
          if (round != LAST_ROUND) begin
            round <= round + 4'd1;
          end
        end
        DONE: begin
          if (host.out_ready) begin
            round <= '0;
          end
        end
        default: begin
          round <= '0;
        end
      endcase
    end
  end

  assign host.in_ready   = (fsm == IDLE);
  assign host.out_valid  = (fsm == DONE);
  assign host.busy       = (fsm == ROUND) || (fsm == DONE);
  assign host.ciphertext = blk_state;

  assign rnd_state_o = blk_state;
  assign rnd_key_o   = kexp_key_i;
  assign rnd_last_o  = (fsm == ROUND) && (round == LAST_ROUND);
  assign kexp_key_o  = rkey;
  assign kexp_rcon_o = rcon;

endmodule
`default_nettype wire

// File: tb/tb_aes128_round_ctrl.sv
`default_nettype none
// ============================================================================
// tb_aes128_round_ctrl : bench with behavioural AES round/key-expansion models
// Revision 1.0
// ============================================================================
module tb_aes128_round_ctrl;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic [7:0] rcon_lit [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  logic         clk   = 1'b0;
  logic         rst_n = 1'b1;
  logic [127:0] kexp_key_o, kexp_key_i, rnd_state_o, rnd_key_o, rnd_state_i;
  logic [7:0]   kexp_rcon_o;
  logic         rnd_last_o;

  aes128_round_ctrl_if host ();

  aes128_round_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .host        (host),
    .kexp_key_o  (kexp_key_o),
    .kexp_rcon_o (kexp_rcon_o),
    .kexp_key_i  (kexp_key_i),
    .rnd_state_o (rnd_state_o),
    .rnd_key_o   (rnd_key_o),
    .rnd_last_o  (rnd_last_o),
    .rnd_state_i (rnd_state_i)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] a;
    for (int v = 0; v < 256; v++) begin
      a   = v[7:0];
      inv = 8'h00;
      if (a != 8'h00) begin
        inv = 8'h01;
        for (int e = 0; e < 254; e++) inv = gmul(inv, a);
      end
      sbox[v] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] kexp_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]} ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] rnd_model(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   a [16];
    logic [7:0]   b [16];
    logic [7:0]   x0, x1, x2, x3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) a[i] = sbox[st[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) b[rr+4*c] = a[rr+4*((c+rr)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        x0 = b[4*c]; x1 = b[4*c+1]; x2 = b[4*c+2]; x3 = b[4*c+3];
        b[4*c]   = gmul(x0, 8'h02) ^ gmul(x1, 8'h03) ^ x2 ^ x3;
        b[4*c+1] = x0 ^ gmul(x1, 8'h02) ^ gmul(x2, 8'h03) ^ x3;
        b[4*c+2] = x0 ^ x1 ^ gmul(x2, 8'h02) ^ gmul(x3, 8'h03);
        b[4*c+3] = gmul(x0, 8'h03) ^ x1 ^ x2 ^ gmul(x3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = b[i];
    return r ^ rk;
  endfunction

  // Whole-block encryption: state after each round and each round key.
  function automatic void aes_ref(input logic [127:0] p, input logic [127:0] k,
                                  output logic [10:0][127:0] rs, output logic [10:0][127:0] rk);
    rk[0] = k;
    rs[0] = p ^ k;
    for (int r = 1; r <= 10; r++) begin
      rk[r] = kexp_step(rk[r-1], rcon_lit[r-1]);
      rs[r] = rnd_model(rs[r-1], rk[r], r == 10);
    end
  endfunction

  function automatic logic [127:0] ref_ct(input logic [127:0] p, input logic [127:0] k);
    logic [10:0][127:0] rs, rk;
    aes_ref(p, k, rs, rk);
    return rs[10];
  endfunction

  // External combinational datapath seen by the controller.
  assign kexp_key_i  = kexp_step(kexp_key_o, kexp_rcon_o);
  assign rnd_state_i = rnd_model(rnd_state_o, rnd_key_o, rnd_last_o);

  // ---------------- transaction-level model ----------------
  // m_cnt: -1 idle, k in 0..9 means state holds the result of k rounds, 10 = result pending.
  int                 m_cnt     = -1;
  int                 m_acc_n   = 0;
  int                 m_acc_cyc = 0;
  int                 cyc       = 0;
  logic [10:0][127:0] m_rs      = '0;
  logic [10:0][127:0] m_rk      = '0;
  logic [127:0]       m_idle_ct = '0;
  logic [7:0]         m_idle_rc = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_cnt     = -1;
      m_idle_ct = '0;
      m_idle_rc = '0;
    end else begin
      cyc++;
      if (m_cnt < 0) begin
        if (host.in_valid) begin
          aes_ref(host.plaintext, host.key, m_rs, m_rk);
          m_cnt     = 0;
          m_acc_n++;
          m_acc_cyc = cyc;
        end
      end else if (m_cnt < 10) begin
        m_cnt++;
      end else if (host.out_ready) begin
        m_cnt     = -1;
        m_idle_ct = m_rs[10];
        m_idle_rc = 8'h6c;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("in_ready", host.in_ready, m_cnt < 0);
      chk("busy", host.busy, m_cnt >= 0);
      chk("out_valid", host.out_valid, m_cnt == 10);
      chk("rnd_last", rnd_last_o, m_cnt == 9);
      if (m_cnt < 0) begin
        chk("idle_ct", host.ciphertext, m_idle_ct);
        chk("idle_rcon", kexp_rcon_o, m_idle_rc);
      end else begin
        chk("ciphertext", host.ciphertext, m_rs[m_cnt]);
        chk("rnd_state_o", rnd_state_o, m_rs[m_cnt]);
        if (m_cnt < 10) begin
          chk("kexp_key_o", kexp_key_o, m_rk[m_cnt]);
          chk("kexp_rcon", kexp_rcon_o, rcon_lit[m_cnt]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input logic [127:0] p, input logic [127:0] k, input bit keep);
    int n0;
    n0 = m_acc_n;
    host.in_valid  = 1'b1;
    host.plaintext = p;
    host.key       = k;
    for (int i = 0; i < 40 && m_acc_n == n0; i++) @(negedge clk);
    chk("accept_seen", m_acc_n != n0, 1);
    if (!keep) host.in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 30 && !host.out_valid; i++) @(negedge clk);
    chk("out_valid_seen", host.out_valid, 1);
  endtask

  task automatic reset_lits(input string tag);
    chk({tag, "_in_ready"}, host.in_ready, 1);
    chk({tag, "_out_valid"}, host.out_valid, 0);
    chk({tag, "_busy"}, host.busy, 0);
    chk({tag, "_ct"}, host.ciphertext, 0);
    chk({tag, "_last"}, rnd_last_o, 0);
    chk({tag, "_rcon"}, kexp_rcon_o, 0);
  endtask

  int           acc0, acc1, acc2, got;
  logic [127:0] v0, k0, v1, k1;
  logic [127:0] res [2];

  initial begin
    host.in_valid  = 1'b0;
    host.plaintext = '0;
    host.key       = '0;
    host.out_ready = 1'b0;
    build_sbox();
    chk("model_c1", ref_ct(C1_PT, C1_KEY), C1_CT);
    chk("model_appb", ref_ct(B_PT, B_KEY), B_CT);
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    reset_lits("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // C.1 with immediate consumer
    host.out_ready = 1'b1;
    send(C1_PT, C1_KEY, 1'b0);
    acc0 = m_acc_cyc;
    wait_valid();
    chk("c1_latency", cyc - acc0, 10);
    chk("c1_ct", host.ciphertext, C1_CT);
    @(negedge clk);
    chk("c1_single_done", host.out_valid, 0);
    @(negedge clk);

    // App. B with per-round constant and last-round flag
    send(B_PT, B_KEY, 1'b0);
    for (int r = 1; r <= 10; r++) begin
      chk("b_rcon", kexp_rcon_o, rcon_lit[r-1]);
      chk("b_last", rnd_last_o, r == 10);
      @(negedge clk);
    end
    chk("b_valid", host.out_valid, 1);
    chk("b_ct", host.ciphertext, B_CT);
    @(negedge clk);

    // Backpressure
    host.out_ready = 1'b0;
    send(C1_PT, C1_KEY, 1'b0);
    wait_valid();
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", host.out_valid, 1);
      chk("bp_ct", host.ciphertext, C1_CT);
      chk("bp_in_ready", host.in_ready, 0);
      @(negedge clk);
    end
    host.out_ready = 1'b1;
    @(negedge clk);
    host.out_ready = 1'b0;
    chk("bp_release_ready", host.in_ready, 1);
    chk("bp_release_valid", host.out_valid, 0);

    // Ignored inputs during ROUND
    host.out_ready = 1'b1;
    send(C1_PT, C1_KEY, 1'b0);
    for (int i = 0; i < 9; i++) begin
      host.in_valid  = 1'($urandom_range(0, 1));
      host.plaintext = {$urandom, $urandom, $urandom, $urandom};
      host.key       = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
    end
    host.in_valid = 1'b0;
    wait_valid();
    chk("ign_ct", host.ciphertext, C1_CT);
    repeat (3) @(negedge clk);
    chk("ign_no_second", host.busy, 0);

    // Reset abort at round 5
    send(C1_PT, C1_KEY, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 reset_lits("abort");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      chk("abort_no_valid", host.out_valid, 0);
      @(negedge clk);
    end
    send(C1_PT, C1_KEY, 1'b0);
    wait_valid();
    chk("abort_rerun_ct", host.ciphertext, C1_CT);
    @(negedge clk);

    // Back-to-back with in_valid held high
    v0 = {$urandom, $urandom, $urandom, $urandom};
    k0 = {$urandom, $urandom, $urandom, $urandom};
    v1 = {$urandom, $urandom, $urandom, $urandom};
    k1 = {$urandom, $urandom, $urandom, $urandom};
    acc0 = m_acc_n;
    send(v0, k0, 1'b1);
    acc1 = m_acc_cyc;
    acc2 = acc1;
    host.plaintext = v1;
    host.key       = k1;
    got = 0;
    for (int i = 0; i < 40 && got < 2; i++) begin
      if (host.out_valid) begin
        res[got] = host.ciphertext;
        got++;
      end
      if (host.in_valid && m_acc_n == acc0 + 2) begin
        acc2 = m_acc_cyc;
        host.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_results", got, 2);
    chk("b2b_spacing", acc2 - acc1, 12);
    chk("b2b_ct0", res[0], ref_ct(v0, k0));
    chk("b2b_ct1", res[1], ref_ct(v1, k1));
    host.in_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Random vectors under random consumer backpressure
    for (int v = 0; v < 5; v++) begin
      host.out_ready = 1'b0;
      send({$urandom, $urandom, $urandom, $urandom},
           {$urandom, $urandom, $urandom, $urandom}, 1'b0);
      for (int i = 0; i < 80 && m_cnt >= 0; i++) begin
        host.out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      chk("rand_back_idle", host.in_ready, 1);
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
